tour_fitness: RTL and testbench

- Downstream of the swap mutation stage; consumes a 150-bit mutant chromosome of 30 five-bit city indices.
- Computes the closed-tour cost by walking consecutive gene pairs through an external distance ROM with one-cycle read latency.
- Also checks that the chromosome is a legal permutation.
- Its fitness and valid outputs feed the selection stage.

---
 rtl/ga_pkg.sv | 32 +++
 rtl/perm_check.sv | 44 ++++
 rtl/tour_fitness.sv | 130 +++++++++++++
 tb/tb_tour_fitness.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared constants and types for the GA pipeline (swap, fitness, selection).
// Also holds gene-mux helpers used by the tour fitness evaluator.
package ga_pkg;

  localparam int N_GENES = 30;                 // genes per chromosome (tour length)
  localparam int GENE_W  = 5;                  // bits per gene (city index)
  localparam int CHROM_W = N_GENES * GENE_W;   // packed chromosome width
  localparam int DIST_W  = 12;                 // distance ROM word width
  localparam int FIT_W   = DIST_W + 5;         // holds N_GENES * (2^DIST_W - 1)

  typedef logic [GENE_W-1:0] gene_t;

  localparam gene_t LAST_IDX = gene_t'(N_GENES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Gene idx of a packed chromosome; gene 0 sits at the LSBs.
  function automatic gene_t gene_at(input logic [CHROM_W-1:0] chrom, input gene_t idx);
    return chrom[idx*GENE_W +: GENE_W];
  endfunction

  // Successor index around the closed tour.
  function automatic gene_t wrap_inc(input gene_t idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/perm_check.sv
// Permutation checker: a seen bitmap plus a sticky bad flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        start of a new chromosome: empties bitmap and bad flag
//   gene_valid   gene carries one city of the chromosome this cycle
//   gene         city index to check
//   bad          set once any gene is out of range or repeated
module perm_check
  import ga_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  gene_valid,
  input  gene_t gene,
  output logic  bad
);

  logic [N_GENES-1:0] seen_q;
  logic               bad_q;

  // NOTE: state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      bad_q  <= 1'b0;
    end else if (clear) begin
      seen_q <= '0;
      bad_q  <= 1'b0;
    end else if (gene_valid) begin
      // The range test comes first so the bitmap is never indexed past its end.
      if (gene > LAST_IDX) begin
        bad_q <= 1'b1;
      end else if (seen_q[gene]) begin
        bad_q <= 1'b1;
      end else begin
        seen_q[gene] <= 1'b1;
      end
    end
  end

  assign bad = bad_q;

endmodule

// File: rtl/tour_fitness.sv
// Tour fitness evaluator: walks the 30 edges of a closed tour through an
// external distance ROM (one-cycle read latency), sums the distances and
// checks that the chromosome is a permutation of 0..N_GENES-1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request evaluation (sampled only in IDLE)
//   chromosome          N_GENES packed genes, gene 0 at the LSBs
//   dist_en             ROM read enable
//   dist_from, dist_to  ROM row / column (hold when dist_en=0)
//   dist_data           ROM word, valid the cycle after dist_en
//   busy                high from the cycle after acceptance through done
//   done                one-cycle pulse, fitness/valid final
//   fitness, valid      tour cost and permutation flag, held until next done
module tour_fitness
  import ga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CHROM_W-1:0] chromosome,
  output logic               dist_en,
  output gene_t              dist_from,
  output gene_t              dist_to,
  input  logic [DIST_W-1:0]  dist_data,
  output logic               busy,
  output logic               done,
  output logic [FIT_W-1:0]   fitness,
  output logic               valid
);

  state_e             state_q;
  gene_t              k_q;
  logic [CHROM_W-1:0] chrom_q;
  logic [FIT_W-1:0]   acc_q;
  logic [FIT_W-1:0]   acc_d;
  logic               rd_pend_q;   // a ROM word arrives this cycle
  logic               dist_en_q;
  gene_t              from_q;
  gene_t              to_q;
  logic               busy_q;
  logic               done_q;
  logic [FIT_W-1:0]   fitness_q;
  logic               valid_q;

  logic accept;
  logic bad;

  assign accept = (state_q == IDLE) && start;
  assign acc_d  = acc_q + FIT_W'(dist_data);

  perm_check u_perm_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .gene_valid (state_q == ISSUE),
    .gene       (gene_at(chrom_q, k_q)),
    .bad        (bad)
  );

  // Outputs are loaded one edge early so that during ISSUE step k the ROM
  // address already reflects edge k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      // NOTE: the chromosome copy is reset as well, so the gene mux never
      // presents X to the checker or ROM address after reset.
      chrom_q   <= '0;
      acc_q     <= '0;
      rd_pend_q <= 1'b0;
      dist_en_q <= 1'b0;
      from_q    <= '0;
      to_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fitness_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= dist_en_q;
      if (rd_pend_q) acc_q <= acc_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            chrom_q   <= chromosome;
            acc_q     <= '0;
            k_q       <= '0;
            dist_en_q <= 1'b1;
            from_q    <= gene_at(chromosome, '0);
            to_q      <= gene_at(chromosome, gene_t'(1));
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (k_q == LAST_IDX) begin
            dist_en_q <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            k_q    <= k_q + 1'b1;
            from_q <= gene_at(chrom_q, k_q + 1'b1);
            to_q   <= gene_at(chrom_q, wrap_inc(k_q + 1'b1));
          end
        end
        DRAIN: begin
          // Edge 29's word is on dist_data now; fold it straight into the result.
          fitness_q <= acc_d;
          valid_q   <= ~bad;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dist_en   = dist_en_q;
  assign dist_from = from_q;
  assign dist_to   = to_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fitness   = fitness_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_tour_fitness.sv
module tb_tour_fitness;
  import ga_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [CHROM_W-1:0] chromosome;
  logic               dist_en;
  logic [GENE_W-1:0]  dist_from;
  logic [GENE_W-1:0]  dist_to;
  logic [DIST_W-1:0]  dist_data;
  logic               busy;
  logic               done;
  logic [FIT_W-1:0]   fitness;
  logic               valid;

  int checks   = 0;
  int failures = 0;

  // ROM contents: 0 = |a-b|, 1 = constant 4095, 2 = random table.
  int rom_mode = 0;
  int rom_tab[32][32];
  int last_fit = 0;
  int last_ok  = 0;

  always #5 clk = ~clk;

  tour_fitness dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chromosome (chromosome),
    .dist_en    (dist_en),
    .dist_from  (dist_from),
    .dist_to    (dist_to),
    .dist_data  (dist_data),
    .busy       (busy),
    .done       (done),
    .fitness    (fitness),
    .valid      (valid)
  );

  function automatic int rom_val(input int a, input int b);
    case (rom_mode)
      0:       return (a > b) ? a - b : b - a;
      1:       return 4095;
      default: return rom_tab[a][b];
    endcase
  endfunction

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (dist_en) dist_data <= DIST_W'(rom_val(int'(dist_from), int'(dist_to)));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: closed-tour sum over the ROM and a city histogram.
  function automatic void model(input logic [CHROM_W-1:0] c, output int fit, output int ok);
    int g[N_GENES];
    int cnt[32];
    for (int i = 0; i < N_GENES; i++) g[i] = int'(c[i*GENE_W +: GENE_W]);
    fit = 0;
    for (int k = 0; k < N_GENES; k++) fit += rom_val(g[k], g[(k + 1) % N_GENES]);
    for (int v = 0; v < 32; v++) cnt[v] = 0;
    for (int i = 0; i < N_GENES; i++) cnt[g[i]]++;
    ok = 1;
    for (int v = 0; v < N_GENES; v++) if (cnt[v] != 1) ok = 0;
  endfunction

  function automatic logic [CHROM_W-1:0] pack(input int g[N_GENES]);
    logic [CHROM_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_GENES; i++) c[i*GENE_W +: GENE_W] = GENE_W'(g[i]);
    return c;
  endfunction

  function automatic logic [CHROM_W-1:0] rand_perm();
    int g[N_GENES];
    int j;
    int t;
    for (int i = 0; i < N_GENES; i++) g[i] = i;
    for (int i = N_GENES - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = g[i]; g[i] = g[j]; g[j] = t;
    end
    return pack(g);
  endfunction

  function automatic logic [CHROM_W-1:0] rand_bits();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[CHROM_W-1:0];
  endfunction

  // One evaluation. poke_cyc: cycle in which a stray start is pulsed.
  // rst_cyc: cycle in which rst_n is pulled low to abort the run.
  task automatic run_eval(input logic [CHROM_W-1:0] chrom, input string tag,
                          input int poke_cyc, input int rst_cyc);
    int exp_fit, exp_ok;
    int cyc, done_cnt, done_cyc, busy_cnt, en_cnt, late_done;
    model(chrom, exp_fit, exp_ok);
    start      = 1'b1;
    chromosome = chrom;
    @(posedge clk); #1;
    start      = 1'b0;
    chromosome = rand_bits();   // must not disturb the running evaluation
    check({tag, "_fit_held_on_start"}, fitness, last_fit);
    cyc = 1; done_cnt = 0; done_cyc = -1; busy_cnt = 0; en_cnt = 0;
    while (cyc <= 40) begin
      if (busy)    busy_cnt++;
      if (dist_en) en_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check({tag, "_fitness"}, fitness, exp_fit);
          check({tag, "_valid"}, valid, exp_ok);
        end
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_fitness"}, fitness, 0);
        check({tag, "_rst_dist_en"}, dist_en, 0);
        check({tag, "_rst_valid"}, valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          if (done) late_done++;
        end
        check({tag, "_no_done_after_abort"}, late_done, 0);
        last_fit = 0;
        last_ok  = 0;
        return;
      end
      start = (cyc == poke_cyc);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 32);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 32);
    check({tag, "_dist_en_cycles"}, en_cnt, 30);
    check({tag, "_fit_held_after"}, fitness, exp_fit);
    last_fit = exp_fit;
    last_ok  = exp_ok;
  endtask

  initial begin
    int g[N_GENES];
    int exp_fit, exp_ok, cyc;
    int done_at[$];
    logic [CHROM_W-1:0] c;

    rst_n      = 1'b0;
    start      = 1'b0;
    chromosome = '0;
    dist_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dist_en", dist_en, 0);
    check("reset_fitness", fitness, 0);
    check("reset_valid", valid, 0);
    check("reset_from", dist_from, 0);
    check("reset_to", dist_to, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // |a-b| ROM: identity, reversed, duplicate, out-of-range.
    rom_mode = 0;
    for (int i = 0; i < N_GENES; i++) g[i] = i;
    run_eval(pack(g), "identity", -1, -1);
    for (int i = 0; i < N_GENES; i++) g[i] = N_GENES - 1 - i;
    run_eval(pack(g), "reversed", -1, -1);
    for (int i = 0; i < N_GENES; i++) g[i] = i;
    g[7] = 3;
    run_eval(pack(g), "duplicate", -1, -1);
    for (int i = 0; i < N_GENES; i++) g[i] = i;
    g[29] = 31;
    run_eval(pack(g), "out_of_range", -1, -1);

    // Saturated ROM: largest possible tour cost.
    rom_mode = 1;
    run_eval(rand_perm(), "max_dist", -1, -1);

    // Stray start mid-run, then abort by reset and a fresh run.
    rom_mode = 0;
    for (int i = 0; i < N_GENES; i++) g[i] = i;
    run_eval(pack(g), "stray_start", 10, -1);
    run_eval(rand_perm(), "abort", -1, 15);
    run_eval(pack(g), "after_abort", -1, -1);

    // Random ROM table with random permutations and random bit patterns.
    rom_mode = 2;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++) rom_tab[a][b] = int'($urandom_range(4095, 0));
    for (int n = 0; n < 6; n++) run_eval(rand_perm(), $sformatf("rand_perm%0d", n), -1, -1);
    for (int n = 0; n < 3; n++) run_eval(rand_bits(), $sformatf("rand_bits%0d", n), -1, -1);
    c = rand_perm();
    c[4:0] = c[9:5];   // duplicate city in an otherwise random tour
    run_eval(c, "rand_dup", -1, -1);

    // start held high: back-to-back evaluations, one per 33 cycles.
    c = rand_perm();
    model(c, exp_fit, exp_ok);
    start      = 1'b1;
    chromosome = c;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc <= 70) begin
      if (done) begin
        done_at.push_back(cyc);
        check($sformatf("held_fitness%0d", done_at.size()), fitness, exp_fit);
        check($sformatf("held_valid%0d", done_at.size()), valid, exp_ok);
      end
      if (cyc >= 34) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("held_done_count", done_at.size(), 2);
    if (done_at.size() >= 2) begin
      check("held_first_done", done_at[0], 32);
      check("held_second_done", done_at[1], 65);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
